// File: rtl/core_dispatch_pkg.sv
// core_dispatch_pkg
// Shared types and constants for the core dispatch controller and its
// result reader: FSM state encoding, per-core status command codes and
// the default parameter values used by both modules.
package core_dispatch_pkg;

  localparam int DEF_NUM_CORES      = 4;
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  localparam logic [1:0] STATUS_OFF = 2'b00;
  localparam logic [1:0] STATUS_RUN = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_READ   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/dispatch_result_reader.sv
// dispatch_result_reader
// Reads i_len words starting at i_base from the data memory and presents
// them one at a time on a valid/ready port through a one-deep output
// register. A read is issued only when the output register is empty (or
// is being emptied this cycle) and no read is already in flight.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   i_start             one-cycle pulse: clear counters and begin
//   i_base, i_len       first address and word count (i_len != 0)
//   o_mem_addr/o_mem_rd_en, i_mem_dataout   memory read port (1-cycle data)
//   o_out_data/o_out_valid, i_out_ready     result stream
//   o_last_acc          one-cycle pulse after the final word is accepted
module dispatch_result_reader
  import core_dispatch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd_en,
  input  logic [DATA_W-1:0] i_mem_dataout,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_last_acc
);

  logic              r_active;
  logic              r_inflight;
  logic              r_out_valid;
  logic              r_last_acc;
  logic [ADDR_W-1:0] r_issue_idx;
  logic [ADDR_W-1:0] r_acc_cnt;
  logic [DATA_W-1:0] r_out_data;

  logic w_pop;
  logic w_more;
  logic w_rd_en;
  logic w_last;

  assign w_pop   = r_out_valid & i_out_ready;
  assign w_more  = (r_issue_idx != i_len);
  // An in-flight read already owns the output register slot.
  assign w_rd_en = r_active & w_more & ~r_inflight & (~r_out_valid | w_pop);
  assign w_last  = w_pop & (r_acc_cnt == (i_len - ADDR_W'(1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
      r_last_acc  <= 1'b0;
      r_issue_idx <= '0;
      r_acc_cnt   <= '0;
      r_out_data  <= '0;
    end else begin
      r_last_acc <= 1'b0;
      r_inflight <= w_rd_en;
      if (i_start) begin
        r_active    <= 1'b1;
        r_issue_idx <= '0;
        r_acc_cnt   <= '0;
      end else begin
        if (w_rd_en) r_issue_idx <= r_issue_idx + ADDR_W'(1);
        if (w_pop) begin
          r_acc_cnt <= r_acc_cnt + ADDR_W'(1);
          if (w_last) begin
            r_active   <= 1'b0;
            r_last_acc <= 1'b1;
          end
        end
      end
      if (r_inflight) begin
        r_out_data  <= i_mem_dataout;
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Address wraps naturally at 2^ADDR_W.
  assign o_mem_addr  = r_active ? (i_base + r_issue_idx) : '0;
  assign o_mem_rd_en = w_rd_en;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_last_acc  = r_last_acc;

endmodule

// File: rtl/core_dispatch_ctrl.sv
// core_dispatch_ctrl
// Host-side run/finish sequencer for a 4-core processor. Drives the per-core
// run commands, collects end_process finish flags, then streams a block of
// result words out of the data memory.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   start, core_mask, result_base, result_len   job launch (IDLE only)
//   status0..status3             per-core command (00 off, 01 run)
//   end_process                  per-core finish level
//   mem_addr, mem_rd_en, mem_dataout            data memory read port
//   out_data, out_valid, out_ready              result stream
//   busy, done, error            job status
// Optional build macro: CORE_DISPATCH_WATCHDOG_EN adds a WAIT-state timeout
// of TIMEOUT_CYCLES cycles that aborts the job and raises a sticky error.
//
// state  | meaning
// IDLE   | waiting for start; job parameters latched on start
// LAUNCH | one cycle; masked cores commanded to run at its end
// WAIT   | collecting finish flags; finished cores switched off
// READ   | result reader streaming result_len words
// DONE   | one-cycle done pulse, then back to IDLE
module core_dispatch_ctrl
  import core_dispatch_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [ADDR_W-1:0]    result_base,
  input  logic [ADDR_W-1:0]    result_len,
  output logic [1:0]           status0,
  output logic [1:0]           status1,
  output logic [1:0]           status2,
  output logic [1:0]           status3,
  input  logic [NUM_CORES-1:0] end_process,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd_en,
  input  logic [DATA_W-1:0]    mem_dataout,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  if (NUM_CORES != 4 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("core_dispatch_ctrl: NUM_CORES must be 4 and TIMEOUT_CYCLES at least 2");
  end

  state_t                      r_state;
  logic [NUM_CORES-1:0]        r_mask;
  logic [NUM_CORES-1:0]        r_done_seen;
  logic [NUM_CORES-1:0][1:0]   r_status;
  logic [ADDR_W-1:0]           r_base;
  logic [ADDR_W-1:0]           r_len;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_rd_start;

  logic [NUM_CORES-1:0]        w_seen_nxt;
  logic                        w_last_acc;

`ifdef CORE_DISPATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_error;
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  // Finish flags from unmasked cores never reach done_seen.
  assign w_seen_nxt = r_done_seen | (end_process & r_mask);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_done_seen <= '0;
      r_status    <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_start  <= 1'b0;
`ifdef CORE_DISPATCH_WATCHDOG_EN
      r_wd_cnt    <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_rd_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mask      <= core_mask;
            r_base      <= result_base;
            r_len       <= result_len;
            r_done_seen <= '0;
            r_busy      <= 1'b1;
`ifdef CORE_DISPATCH_WATCHDOG_EN
            r_error     <= 1'b0;
`endif
            if (core_mask != '0) begin
              r_state <= ST_LAUNCH;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          for (int i = 0; i < NUM_CORES; i++)
            r_status[i] <= r_mask[i] ? STATUS_RUN : STATUS_OFF;
`ifdef CORE_DISPATCH_WATCHDOG_EN
          // Down-counter reaches zero in the TIMEOUT_CYCLES-th WAIT cycle.
          r_wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_done_seen <= w_seen_nxt;
          for (int i = 0; i < NUM_CORES; i++)
            if (w_seen_nxt[i]) r_status[i] <= STATUS_OFF;
          // Uses the next done_seen so a flag arriving this cycle counts now.
          if (w_seen_nxt == r_mask) begin
            if (r_len != '0) begin
              r_state    <= ST_READ;
              r_rd_start <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
`ifdef CORE_DISPATCH_WATCHDOG_EN
          else if (r_wd_cnt == '0) begin
            r_status <= '0;
            r_error  <= 1'b1;
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt - WD_W'(1);
          end
`endif
        end
        ST_READ: begin
          if (w_last_acc) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  dispatch_result_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_reader (
    .clock         (clock),
    .reset         (reset),
    .i_start       (r_rd_start),
    .i_base        (r_base),
    .i_len         (r_len),
    .o_mem_addr    (mem_addr),
    .o_mem_rd_en   (mem_rd_en),
    .i_mem_dataout (mem_dataout),
    .o_out_data    (out_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_last_acc    (w_last_acc)
  );

  assign status0 = r_status[0];
  assign status1 = r_status[1];
  assign status2 = r_status[2];
  assign status3 = r_status[3];
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_core_dispatch_ctrl.sv
module tb_core_dispatch_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  core_mask;
  logic [7:0]  result_base;
  logic [7:0]  result_len;
  logic [1:0]  status0, status1, status2, status3;
  logic [3:0]  end_process;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_dataout;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        error;

  core_dispatch_ctrl #(
    .NUM_CORES      (4),
    .ADDR_W         (8),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .core_mask   (core_mask),
    .result_base (result_base),
    .result_len  (result_len),
    .status0     (status0),
    .status1     (status1),
    .status2     (status2),
    .status3     (status3),
    .end_process (end_process),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_dataout (mem_dataout),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read data memory: data appears the cycle after the request.
  logic [15:0] mem [256];
  logic [15:0] mem_q;
  always @(posedge clock) if (mem_rd_en) mem_q <= mem[mem_addr];
  assign mem_dataout = mem_q;

  logic [1:0] st [4];
  always_comb begin
    st[0] = status0;
    st[1] = status1;
    st[2] = status2;
    st[3] = status3;
  end

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0]  exp_addr [$];
  logic [15:0] exp_data [$];

  int rd_mode      = 0;
  int bp_left      = 0;
  bit bp_used      = 0;
  int cyc          = 0;
  int last_acc_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = one 10-cycle stall.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (rd_mode == 2 && !bp_used && out_valid) begin
        bp_left = 10;
        bp_used = 1;
      end
      if (bp_left > 0) begin
        out_ready = 1'b0;
        bp_left--;
      end else if (rd_mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: checks every read address and accepted word against the
  // scoreboard queues plus the stream invariants.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) fail_now("rd_extra", 32'(mem_addr), 32'hFFFF_FFFF);
        else chk("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
      if (out_valid) begin
        chk("valid_no_done", 32'(done), 32'd0);
        chk("valid_busy", 32'(busy), 32'd1);
        if (!out_ready) chk("stall_no_rd", 32'(mem_rd_en), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) fail_now("out_extra", 32'(out_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(out_data), 32'(exp_data.pop_front()));
        if (rd_mode == 0 && last_acc_cyc >= 0) chk("throughput_gap", 32'(cyc - last_acc_cyc), 32'd2);
        last_acc_cyc = cyc;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic run_job(input logic [3:0] mask, input logic [7:0] base, input logic [7:0] len,
                         input int d0, input int d1, input int d2, input int d3, input int rmode);
    int  d [4];
    int  maxd;
    bit  got_done;
    logic [3:0] ep_v;
    d = '{d0, d1, d2, d3};
    maxd = 0;
    for (int i = 0; i < 4; i++) if (mask[i] && d[i] > maxd) maxd = d[i];
    if (mask != 4'b0000) begin
      for (int i = 0; i < int'(len); i++) begin
        logic [7:0] a;
        a = base + 8'(i);
        exp_addr.push_back(a);
        exp_data.push_back(mem[a]);
      end
    end
    rd_mode = rmode;
    bp_used = 0;
    last_acc_cyc = -1;

    @(posedge clock); #1;
    core_mask = mask; result_base = base; result_len = len; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    core_mask = 4'($urandom); result_base = 8'($urandom); result_len = 8'($urandom);
    @(negedge clock);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_error_clr", 32'(error), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("accept_status%0d", i), 32'(st[i]), 32'd0);
    if (mask == 4'b0000) begin
      chk("mask0_done", 32'(done), 32'd1);
    end else begin
      chk("launch_done", 32'(done), 32'd0);
      for (int k = 0; k <= maxd + 1; k++) begin
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++)
          ep_v[i] = mask[i] ? (d[i] == k) : 1'($urandom_range(0, 1));
        end_process = ep_v;
        start = (k <= maxd) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clock);
        for (int i = 0; i < 4; i++)
          chk($sformatf("status%0d_k%0d", i, k), 32'(st[i]),
              (mask[i] && k <= d[i]) ? 32'd1 : 32'd0);
        chk($sformatf("wait_no_rd_k%0d", k), 32'(mem_rd_en), 32'd0);
        chk($sformatf("wait_done_k%0d", k), 32'(done), (k == maxd + 1 && len == 0) ? 32'd1 : 32'd0);
      end
      end_process = 4'b0000;
      start = 1'b0;
      if (len != 0) begin
        @(posedge clock); #1;
        @(negedge clock);
        chk("first_rd_latency", 32'(mem_rd_en), 32'd1);
        got_done = 0;
        for (int t = 0; t < 600 && !got_done; t++) begin
          @(posedge clock); #1;
          @(negedge clock);
          if (done) got_done = 1;
        end
        if (!got_done) fail_now("done_timeout", 32'd0, 32'd1);
      end
    end
    @(posedge clock); #1;
    @(negedge clock);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done_pulse", 32'(done), 32'd0);
    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("data_queue_empty", 32'(exp_data.size()), 32'd0);
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; core_mask = '0; result_base = '0; result_len = '0;
    end_process = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'hFE] = 16'h0011; mem[8'hFF] = 16'h0022;
    mem[8'h00] = 16'h0033; mem[8'h01] = 16'h0044;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_status0", 32'(status0), 32'd0);
    chk("rst_status1", 32'(status1), 32'd0);
    chk("rst_status2", 32'(status2), 32'd0);
    chk("rst_status3", 32'(status3), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_job(4'b0001, 8'h00, 8'd0, 3, 0, 0, 0, 0);
    run_job(4'b1010, 8'h10, 8'd3, 0, 7, 0, 2, 0);
    run_job(4'b0110, 8'hFE, 8'd4, 0, 1, 3, 0, 0);
    run_job(4'b0100, 8'h40, 8'd6, 0, 0, 2, 0, 2);
    run_job(4'b0000, 8'h20, 8'd5, 0, 0, 0, 0, 0);
    run_job(4'b0011, 8'h30, 8'd2, 4, 4, 0, 0, 0);
    run_job(4'b1111, 8'hF8, 8'd12, 1, 5, 0, 2, 1);

    for (int j = 0; j < 12; j++)
      run_job(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 10)),
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 6), $urandom_range(0, 2));

`ifdef CORE_DISPATCH_WATCHDOG_EN
    begin
      logic [3:0] wmask;
      wmask = 4'($urandom_range(1, 15));
      @(posedge clock); #1;
      core_mask = wmask; result_base = 8'h55; result_len = 8'd3; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      for (int k = 0; k <= 16; k++) begin
        @(posedge clock); #1;
        end_process = ~wmask & 4'($urandom);
        @(negedge clock);
        for (int i = 0; i < 4; i++)
          chk($sformatf("wd_status%0d_k%0d", i, k), 32'(st[i]),
              (wmask[i] && k < 16) ? 32'd1 : 32'd0);
        chk($sformatf("wd_error_k%0d", k), 32'(error), (k == 16) ? 32'd1 : 32'd0);
        chk($sformatf("wd_done_k%0d", k), 32'(done), (k == 16) ? 32'd1 : 32'd0);
        chk($sformatf("wd_no_rd_k%0d", k), 32'(mem_rd_en), 32'd0);
      end
      end_process = 4'b0000;
      @(posedge clock); #1;
      @(negedge clock);
      chk("wd_idle_busy", 32'(busy), 32'd0);
      chk("wd_error_sticky", 32'(error), 32'd1);
    end
`endif

    // Reset in the middle of WAIT with every core running.
    @(posedge clock); #1;
    core_mask = 4'b1111; result_base = 8'h70; result_len = 8'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) chk($sformatf("pre_rst_status%0d", i), 32'(st[i]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("async_rst_status%0d", i), 32'(st[i]), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    run_job(4'b1111, 8'h80, 8'd3, 2, 0, 4, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
